uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 SHALL have parameter DATA_BITS, default 8: byte width, matching uart_tx.
REQ-003 SHALL have port clock, input, 1: sole clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ: bit i means requester i offers a byte.
REQ-006 SHALL have port req_data, input, NUM_REQ*DATA_BITS: byte of requester i at bits [i*DATA_BITS +: DATA_BITS].
REQ-007 SHALL have port req_last, input, NUM_REQ: bit i marks requester i's byte as the last byte of its packet.
REQ-008 SHALL have port req_ready, output, NUM_REQ: one-cycle accept strobe per requester.
REQ-009 SHALL have port tx_data, output, DATA_BITS: byte to uart_tx.
REQ-010 SHALL have port tx_send, output, 1: one-cycle send pulse to uart_tx.
REQ-011 SHALL have port tx_busy, input, 1: busy flag from uart_tx.
REQ-012 SHALL have port grant_id, output, $clog2(NUM_REQ): requester that owns the current or last byte.
REQ-013 SHALL have port arb_busy, output, 1: high whenever the FSM state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, WAIT_START and WAIT_DONE.
REQ-015 IDLE: when tx_busy=0 and any eligible req_valid=1, SHALL select a winner by round-robin, with highest priority at pointer rr_ptr and descending from there mod NUM_REQ.
REQ-016 req_ready[winner] SHALL be combinational, high only in that IDLE cycle; at most one req_ready bit SHALL be high in any cycle.
REQ-017 In the accept cycle, the design SHALL register req_data of the winner into tx_data, update grant_id, and go to SEND.
REQ-018 SEND SHALL assert tx_send for exactly one cycle, one cycle after the accept, then go to WAIT_START.
REQ-019 WAIT_START SHALL stay until tx_busy=1, then go to WAIT_DONE; WAIT_DONE SHALL stay until tx_busy=0, then go to IDLE.
REQ-020 Minimum byte-to-byte accept spacing SHALL be 4 cycles plus the uart_tx frame time.
REQ-021 Requesters SHALL hold req_valid, req_data and req_last stable until req_ready; the arbiter SHALL never drop an accepted byte.
REQ-022 After a release, rr_ptr SHALL become (winner+1) mod NUM_REQ; wrap-around from NUM_REQ-1 SHALL go to 0.
REQ-023 IDLE with tx_busy=1 (external or stale) SHALL grant nothing.
REQ-024 tx_data SHALL stay stable from SEND until the next accept.
REQ-025 A requester deasserting req_valid before it is granted SHALL simply lose eligibility, with no side effect.

Reset
REQ-026 On reset, the design SHALL set: state IDLE, rr_ptr 0, grant_id 0, tx_data 0, tx_send 0, req_ready 0, arb_busy 0, lock cleared.
REQ-027 Reset mid-byte (any state) SHALL take effect immediately and discard the in-flight byte; there SHALL be no tx_send after reset deasserts until a new accept.

Configuration
REQ-028 The macro UART_ARB_LOCK_EN SHALL select packet locking.
REQ-029 With UART_ARB_LOCK_EN defined: accepting a byte with req_last=0 SHALL lock ownership to that requester; only the owner SHALL be eligible in IDLE; the lock SHALL release and rr_ptr SHALL update only on accept of the owner's byte with req_last=1; if the owner holds req_valid=0, the arbiter SHALL wait indefinitely.
REQ-030 Without UART_ARB_LOCK_EN: req_last SHALL be ignored, and every accepted byte SHALL count as a release (byte-level round-robin).

Structure
REQ-031 Package uart_arb_pkg SHALL hold the FSM state enum typedef (arb_state_t) and the constant MAX_REQ=8.
REQ-032 A sub-module rr_arbiter SHALL implement the combinational round-robin picker: inputs request vector and pointer; outputs one-hot grant and index.
REQ-033 The top level SHALL hold the FSM, rr_ptr, the lock register and the tx_data register; uart_tx SHALL be instantiated outside, beside this block.

Verification
REQ-034 Verification SHALL use NUM_REQ=4 and a uart_tx model with busy lasting 20 cycles, and SHALL cover the following scenarios.
REQ-035 Single byte: req_valid=4'b0100 with data 0x5A -> req_ready[2] pulses, tx_send 1 cycle later, tx_data=0x5A, grant_id=2.
REQ-036 Fairness: all four valid continuously, lock off -> grant order 0,1,2,3,0,1; each requester receives 1 of every 4 bytes.
REQ-037 Wrap: rr_ptr=3 with req_valid=4'b1001 -> grant 3 first, then 0.
REQ-038 Lock on: requester 1 sends 3 bytes (last on the 3rd) while requester 2 is valid -> bytes 1,1,1 then 2; without the macro -> 1,2,1,2.
REQ-039 Reset asserted in WAIT_DONE -> all outputs are at reset values in the same cycle; no tx_send after release until a new valid.
REQ-040 tx_busy held high externally in IDLE with req_valid=4'b0001 -> no req_ready until tx_busy=0, then grant 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: FSM state type and limits shared by the UART transmit arbiter.
package uart_arb_pkg;
    localparam int MAX_REQ = 8;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; ptr_i has top priority, then ptr_i+1, ... mod N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);
    logic [IW-1:0] c;
    always_comb begin
        c = '0;
        idx_o = '0;
        valid_o = 1'b0;
        grant_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = IW'((int'(ptr_i) + k) % N);
            if (req_i[c]) begin
                idx_o = c;
                valid_o = 1'b1;
            end
        end
        if (valid_o) grant_o[idx_o] = 1'b1;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin multiplexer of byte requesters onto one uart_tx.
// Define UART_ARB_LOCK_EN to keep ownership until the owner's req_last byte (packet locking).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_BITS = 8,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_BITS-1:0]           tx_data,
    output logic                           tx_send,
    input  logic                           tx_busy,
    output logic [IW-1:0]                  grant_id,
    output logic                           arb_busy
);
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ out of range");
    end

    arb_state_t state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] elig, win_grant;
    logic [IW-1:0] win_idx;
    logic win_valid, accept, rel;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;
    // While locked, only the owner (last granted requester) may be picked.
    assign elig = lock_q ? (req_valid & (NUM_REQ'(1) << grant_id_q)) : req_valid;
    assign rel = accept & req_last[win_idx];
    assign lock_d = accept ? !req_last[win_idx] : lock_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lock_q <= 1'b0;
        else lock_q <= lock_d;
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign elig = req_valid;
    assign rel = accept;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i   (elig),
        .ptr_i   (rr_ptr_q),
        .grant_o (win_grant),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // Gating with reset keeps req_ready low while reset is held.
    assign accept = !reset && state_q == IDLE && !tx_busy && win_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? SEND :
                  (state_q == SEND) ? WAIT_START :
                  (state_q == WAIT_START && tx_busy) ? WAIT_DONE :
                  (state_q == WAIT_DONE && !tx_busy) ? IDLE : state_q;
    end

    always_comb begin
        req_ready = accept ? win_grant : '0;
        tx_send = state_q == SEND;
        arb_busy = state_q != IDLE;
    end

    always_comb begin
        rr_ptr_d = !rel ? rr_ptr_q : (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        tx_data_d = accept ? req_data[int'(win_idx) * DATA_BITS +: DATA_BITS] : tx_data_q;
        grant_id_d = accept ? win_idx : grant_id_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            grant_id_q <= '0;
            tx_data_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_data = tx_data_q;
    assign grant_id = grant_id_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks of uart_tx_arbiter against a packet-level grant-order model.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int DB = 8;
    localparam int BUSY_LEN = 20;

    logic clock = 0;
    logic reset = 0;
    logic [N-1:0] req_valid = '0;
    logic [N*DB-1:0] req_data = '0;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] req_ready;
    logic [DB-1:0] tx_data;
    logic tx_send;
    logic tx_busy = 0;
    logic [1:0] grant_id;
    logic arb_busy;

    always #5 clock = ~clock;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_send(tx_send),
        .tx_busy(tx_busy), .grant_id(grant_id), .arb_busy(arb_busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] buf_q [N][128];
    int hd[N];
    int tl[N];
    int exp_id[$];
    logic [7:0] exp_dat[$];
    int acc_log[$];
    int m_ptr = 0;
    int m_own = 0;
    bit m_lock = 0;
    int busy_cnt = 0;
    bit ext_busy = 0;
    int pop_id = -1;
    bit pend_send = 0;
    int send_id = 0;
    logic [7:0] send_dat = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit last);
        buf_q[r][tl[r]] = {last, d};
        tl[r]++;
    endtask

    task automatic apply_inputs();
        for (int r = 0; r < N; r++) begin
            req_valid[r] = hd[r] < tl[r];
            req_data[r*DB +: DB] = buf_q[r][hd[r]][7:0];
            req_last[r] = buf_q[r][hd[r]][8];
        end
    endtask

    // Reference: grant order from the round-robin/locking rules over all queued bytes.
    task automatic plan();
        int h[N];
        int w;
        for (int r = 0; r < N; r++) h[r] = hd[r];
        if (pop_id >= 0) h[pop_id]++;
        forever begin
            w = -1;
            if (m_lock) begin
                if (h[m_own] < tl[m_own]) w = m_own;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c = (m_ptr + k) % N;
                    if (w < 0 && h[c] < tl[c]) w = c;
                end
            end
            if (w < 0) break;
            exp_id.push_back(w);
            exp_dat.push_back(buf_q[w][h[w]][7:0]);
`ifdef UART_ARB_LOCK_EN
            m_lock = !buf_q[w][h[w]][8];
            m_own = w;
            if (!m_lock) m_ptr = (w + 1) % N;
`else
            m_ptr = (w + 1) % N;
`endif
            h[w]++;
        end
    endtask

    task automatic cyc();
        int a;
        @(negedge clock);
        if (pend_send) begin
            chk("tx_send", tx_send, 1);
            chk("tx_data", tx_data, send_dat);
            chk("grant_id", grant_id, send_id);
            chk("arb_busy_send", arb_busy, 1);
            pend_send = 0;
        end else begin
            chk("tx_send_quiet", tx_send, 0);
        end
        if (tx_send === 1'b1) busy_cnt = BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = ext_busy || busy_cnt > 0;
        if (pop_id >= 0) begin
            hd[pop_id]++;
            pop_id = -1;
        end
        apply_inputs();
        #1;
        chk("ready_onehot0", $countones(req_ready) <= 1, 1);
        if (req_ready != 0) begin
            a = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) a = i;
            acc_log.push_back(a);
            if (hd[a] < tl[a]) pop_id = a;
            if (exp_id.size() == 0) begin
                chk("unexpected_grant", req_ready, 0);
            end else begin
                send_id = exp_id.pop_front();
                send_dat = exp_dat.pop_front();
                chk("ready_winner", req_ready, 32'(1) << send_id);
                chk("arb_busy_accept", arb_busy, 0);
                pend_send = 1;
            end
        end
    endtask

    task automatic run(input int budget);
        int c = 0;
        while ((exp_id.size() > 0 || pend_send) && c < budget) begin
            cyc();
            c++;
        end
        chk("drain_timeout", exp_id.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < N; r++) begin
            hd[r] = 0;
            tl[r] = 0;
        end
        #1 reset = 1;
        req_valid = 4'b1111;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_arb_busy", arb_busy, 0);
        req_valid = '0;
        reset = 0;

        // Fairness: all four requesters, two bytes each
        acc_log.delete();
        for (int i = 0; i < 8; i++) push(i % N, 8'(8'h10 + i), 1);
        plan();
        run(400);
        for (int i = 0; i < 8; i++) chk($sformatf("fair_%0d", i), acc_log[i], i % N);

        // Single byte from requester 2
        acc_log.delete();
        push(2, 8'h5A, 1);
        plan();
        run(100);
        chk("single_id", acc_log[0], 2);

        // Wrap: pointer now 3, requesters 3 and 0
        acc_log.delete();
        push(0, 8'hA0, 1);
        push(3, 8'hA3, 1);
        plan();
        run(200);
        chk("wrap_1st", acc_log[0], 3);
        chk("wrap_2nd", acc_log[1], 0);

        // Packet: requester 1 sends 3 bytes while requester 2 has 2 bytes
        acc_log.delete();
        push(1, 8'hB1, 0);
        push(1, 8'hB2, 0);
        push(1, 8'hB3, 1);
        push(2, 8'hC1, 0);
        push(2, 8'hC2, 1);
        plan();
        run(400);
`ifdef UART_ARB_LOCK_EN
        chk("pkt_3rd", acc_log[2], 1);
        chk("pkt_4th", acc_log[3], 2);
`else
        chk("pkt_2nd", acc_log[1], 2);
        chk("pkt_4th", acc_log[3], 2);
`endif

        // External busy blocks any grant
        acc_log.delete();
        ext_busy = 1;
        push(0, 8'h3C, 1);
        plan();
        repeat (30) begin
            cyc();
            chk("busy_no_ready", req_ready, 0);
        end
        ext_busy = 0;
        run(100);
        chk("busy_then_0", acc_log[0], 0);

        // Randomized rounds; packets always end with a last byte
        for (int rnd = 0; rnd < 6; rnd++) begin
            bit any = 0;
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 1) == 1 || (r == N - 1 && !any)) begin
                    int nb = $urandom_range(1, 3);
                    any = 1;
                    for (int b = 0; b < nb; b++) push(r, 8'($urandom), b == nb - 1);
                end
            end
            plan();
            run(1000);
        end

        // Reset in WAIT_DONE discards the byte in flight
        acc_log.delete();
        push(1, 8'hC3, 1);
        plan();
        run(100);
        repeat (6) cyc();
        chk("pre_rst_busy", arb_busy, 1);
        #2 reset = 1;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_tx_send", tx_send, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_grant_id", grant_id, 0);
        chk("mid_rst_arb_busy", arb_busy, 0);
        m_ptr = 0;
        m_lock = 0;
        busy_cnt = 0;
        pend_send = 0;
        repeat (2) cyc();
        reset = 0;
        repeat (40) cyc();
        acc_log.delete();
        push(3, 8'hD3, 1);
        push(1, 8'hD1, 1);
        plan();
        run(200);
        chk("post_rst_1st", acc_log[0], 1);
        repeat (30) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
